// File: rtl/qreg_seq.sv
// Command sequencer for a 4-bit Q register: turns one load/clear/shift/nop
// request into the per-cycle C/D command stream and reports the resulting Q.
module qreg_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  input  logic [CNT_W-1:0] req_cnt,
  output logic [2:0]       C,
  output logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       state_dbg
);

  // Handshake: a request is taken on the rising edge where req_valid and
  // req_ready are both high; the requester holds req_* stable until then.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  localparam logic [2:0] C_LOAD  = 3'b000;
  localparam logic [2:0] C_CLEAR = 3'b001;
  localparam logic [2:0] C_SHIFT = 3'b010;
  localparam logic [2:0] C_HOLD  = 3'b011;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       c_nxt;
  logic [WIDTH-1:0] d_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             done_nxt;
  logic             accept;

  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      C      <= C_HOLD;
      D      <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      C      <= c_nxt;
      D      <= d_nxt;
      result <= result_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    c_nxt      = C;
    d_nxt      = D;
    result_nxt = result;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        c_nxt = C_HOLD;
        if (accept) begin
          case (req_op)
            OP_LOAD: begin
              c_nxt     = C_LOAD;
              d_nxt     = req_data;
              cnt_nxt   = CNT_ONE;
              state_nxt = CMD;
            end
            OP_CLEAR: begin
              c_nxt     = C_CLEAR;
              cnt_nxt   = CNT_ONE;
              state_nxt = CMD;
            end
            OP_SHIFT: begin
              // A zero-length shift issues no command and behaves like nop.
              if (req_cnt != '0) begin
                c_nxt     = C_SHIFT;
                cnt_nxt   = req_cnt;
                state_nxt = CMD;
              end else begin
                state_nxt = FIN;
              end
            end
            OP_NOP: begin
              state_nxt = FIN;
            end
            default: begin
              state_nxt = FIN;
            end
          endcase
        end
      end
      CMD: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          c_nxt     = C_HOLD;
          state_nxt = FIN;
        end
      end
      FIN: begin
        // The register has applied the last command by now; sample its Q.
        c_nxt      = C_HOLD;
        result_nxt = q_in;
        done_nxt   = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        c_nxt     = C_HOLD;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
